// File: rtl/uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package    : uart_pkg                                                   |
// | Purpose    : Shared UART baud definitions. Provides the 3-bit rate code |
// |              enum, the baud rate for each code in Hz, and the function  |
// |              that turns a baud rate into a phase-accumulator increment. |
// | Ports      : none (package)                                            |
// | Revision   : 1.0  initial release                                      |
// +------------------------------------------------------------------------+
package uart_pkg;

  // Codes 0-3 keep the legacy 4-rate divider encoding.
  typedef enum logic [2:0] {
    BAUD_4800   = 3'd0,
    BAUD_9600   = 3'd1,
    BAUD_19200  = 3'd2,
    BAUD_38400  = 3'd3,
    BAUD_57600  = 3'd4,
    BAUD_115200 = 3'd5,
    BAUD_230400 = 3'd6,
    BAUD_460800 = 3'd7
  } baud_rate_e;

  localparam int unsigned BAUD_TABLE [8] = '{
    4800, 9600, 19200, 38400, 57600, 115200, 230400, 460800
  };

  // round(2^acc_w * baud * os / clk_hz). 64-bit arithmetic is enough for
  // any realistic clock and an accumulator width up to about 32 bits.
  function automatic longint unsigned baud_inc(
    input longint unsigned clk_hz,
    input longint unsigned baud,
    input longint unsigned os,
    input int unsigned     acc_w
  );
    longint unsigned num;
    num = (64'd1 << acc_w) * baud * os;
    return (num + (clk_hz / 64'd2)) / clk_hz;
  endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_baud_tick_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module     : uart_baud_tick_gen                                        |
// | Purpose    : Fractional-N baud tick generator. A phase accumulator     |
// |              produces an oversample tick (OVERSAMPLE x baud); a phase  |
// |              counter derives bit-centre and bit-boundary ticks and a   |
// |              legacy square-wave baud clock. Rate changes are deferred  |
// |              to a bit boundary so no bit is ever split between rates.  |
// | Ports      : clk_i         system clock, posedge                       |
// |              resetn_i      synchronous active-low reset                |
// |              en_i          run enable; 0 clears accumulator and phase  |
// |              rate_sel_i    requested rate code (uart_pkg::baud_rate_e) |
// |              resync_i      restart bit phase (Rx start edge)           |
// |              os_tick_o     oversample tick pulse                       |
// |              mid_tick_o    bit-centre tick pulse                       |
// |              bit_tick_o    bit-boundary tick pulse                     |
// |              baud_clk_o    square wave, high in second half of a bit   |
// |              os_phase_o    oversample index 0..OVERSAMPLE-1            |
// |              rate_active_o rate code currently in use                  |
// |              rate_ack_o    pulse when a new rate takes effect          |
// | Revision   : 1.0  initial release                                      |
// +------------------------------------------------------------------------+
module uart_baud_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 36_000_000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned ACC_W      = 24
) (
  input  logic                          clk_i,
  input  logic                          resetn_i,
  input  logic                          en_i,
  input  logic [2:0]                    rate_sel_i,
  input  logic                          resync_i,
  output logic                          os_tick_o,
  output logic                          mid_tick_o,
  output logic                          bit_tick_o,
  output logic                          baud_clk_o,
  output logic [$clog2(OVERSAMPLE)-1:0] os_phase_o,
  output logic [2:0]                    rate_active_o,
  output logic                          rate_ack_o
);

  localparam int unsigned PH_W = $clog2(OVERSAMPLE);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(OVERSAMPLE / 2);
  localparam logic [PH_W-1:0] PH_PRE_HALF = PH_W'(OVERSAMPLE / 2 - 1);

  if ((OVERSAMPLE % 2 != 0) || (OVERSAMPLE < 4)) begin : g_bad_oversample
    $error("uart_baud_tick_gen: OVERSAMPLE must be even and >= 4");
  end

  // Per-rate increments, fixed at elaboration.
  logic [ACC_W-1:0] inc_tab [8];

  for (genvar gi = 0; gi < 8; gi++) begin : g_inc
    localparam longint unsigned INC_FULL =
      baud_inc(64'(CLK_HZ), 64'(BAUD_TABLE[gi]), 64'(OVERSAMPLE), ACC_W);
    // INC >= 2^(ACC_W-1) would ask for an oversample rate above CLK_HZ/2.
    if ((INC_FULL == 64'd0) || (INC_FULL >= (64'd1 << (ACC_W - 1)))) begin : g_bad_inc
      $error("uart_baud_tick_gen: rate code %0d unreachable at this CLK_HZ/ACC_W", gi);
    end
    assign inc_tab[gi] = ACC_W'(INC_FULL);
  end

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [PH_W-1:0]  os_phase_q, os_phase_d;
  logic             os_tick_q, os_tick_d;
  logic             mid_tick_q, mid_tick_d;
  logic             bit_tick_q, bit_tick_d;
  logic             baud_clk_q, baud_clk_d;
  baud_rate_e       rate_active_q, rate_active_d;
  logic             rate_ack_q, rate_ack_d;

  logic [ACC_W:0]   sum;
  logic             carry;
  logic             rate_pending;

  always_comb begin
    sum          = {1'b0, acc_q} + {1'b0, inc_tab[rate_active_q]};
    carry        = sum[ACC_W];
    // No separate pending flag: comparing against the live request means the
    // latest rate_sel always wins, and a request that reverts is dropped.
    rate_pending = (baud_rate_e'(rate_sel_i) != rate_active_q);

    acc_d         = sum[ACC_W-1:0];
    os_phase_d    = os_phase_q;
    os_tick_d     = carry;
    mid_tick_d    = carry && (os_phase_q == PH_PRE_HALF);
    bit_tick_d    = carry && (os_phase_q == PH_LAST);
    rate_active_d = rate_active_q;
    rate_ack_d    = 1'b0;

    if (carry) begin
      os_phase_d = (os_phase_q == PH_LAST) ? '0 : os_phase_q + PH_W'(1);
    end

    // The carry that ends this bit still used the old increment; the new one
    // is applied from the following edge, so the next bit is whole.
    if (bit_tick_d && rate_pending) begin
      rate_active_d = baud_rate_e'(rate_sel_i);
      rate_ack_d    = 1'b1;
    end

    if (!en_i) begin
      acc_d         = '0;
      os_phase_d    = '0;
      os_tick_d     = 1'b0;
      mid_tick_d    = 1'b0;
      bit_tick_d    = 1'b0;
      rate_active_d = baud_rate_e'(rate_sel_i);
      rate_ack_d    = rate_pending;
    end else if (resync_i) begin
      // A carry landing on the resync edge is discarded on purpose.
      acc_d         = '0;
      os_phase_d    = '0;
      os_tick_d     = 1'b0;
      mid_tick_d    = 1'b0;
      bit_tick_d    = 1'b0;
      rate_active_d = baud_rate_e'(rate_sel_i);
      rate_ack_d    = rate_pending;
    end

    // Derived from the next phase, so it only moves on mid/bit tick cycles.
    baud_clk_d = (os_phase_d >= PH_HALF);
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      acc_q         <= '0;
      os_phase_q    <= '0;
      os_tick_q     <= 1'b0;
      mid_tick_q    <= 1'b0;
      bit_tick_q    <= 1'b0;
      baud_clk_q    <= 1'b0;
      rate_active_q <= baud_rate_e'(rate_sel_i);
      rate_ack_q    <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      os_phase_q    <= os_phase_d;
      os_tick_q     <= os_tick_d;
      mid_tick_q    <= mid_tick_d;
      bit_tick_q    <= bit_tick_d;
      baud_clk_q    <= baud_clk_d;
      rate_active_q <= rate_active_d;
      rate_ack_q    <= rate_ack_d;
    end
  end

  assign os_tick_o     = os_tick_q;
  assign mid_tick_o    = mid_tick_q;
  assign bit_tick_o    = bit_tick_q;
  assign baud_clk_o    = baud_clk_q;
  assign os_phase_o    = os_phase_q;
  assign rate_active_o = rate_active_q;
  assign rate_ack_o    = rate_ack_q;

endmodule : uart_baud_tick_gen
`default_nettype wire

// File: tb/tb_uart_baud_tick_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module     : tb_uart_baud_tick_gen                                     |
// | Purpose    : Self-checking bench for uart_baud_tick_gen.               |
// |              DUT A runs at 19.6608 MHz where every rate code is legal  |
// |              and codes 2/3 divide exactly (rate 3: 32 clk per os_tick, |
// |              rate 2: 64 clk). DUT B uses the default parameters.       |
// | Ports      : none                                                      |
// | Revision   : 1.0  initial release                                      |
// +------------------------------------------------------------------------+
module tb_uart_baud_tick_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A
  logic       a_resetn, a_en, a_resync;
  logic [2:0] a_rate;
  logic       a_os, a_mid, a_bt, a_baud, a_ack;
  logic [3:0] a_ph;
  logic [2:0] a_ra;

  // DUT B
  logic       b_resetn, b_en, b_resync;
  logic [2:0] b_rate;
  logic       b_os, b_mid, b_bt, b_baud, b_ack;
  logic [3:0] b_ph;
  logic [2:0] b_ra;

  uart_baud_tick_gen #(
    .CLK_HZ     (19_660_800),
    .OVERSAMPLE (16),
    .ACC_W      (24)
  ) u_dut_a (
    .clk_i         (clk),
    .resetn_i      (a_resetn),
    .en_i          (a_en),
    .rate_sel_i    (a_rate),
    .resync_i      (a_resync),
    .os_tick_o     (a_os),
    .mid_tick_o    (a_mid),
    .bit_tick_o    (a_bt),
    .baud_clk_o    (a_baud),
    .os_phase_o    (a_ph),
    .rate_active_o (a_ra),
    .rate_ack_o    (a_ack)
  );

  uart_baud_tick_gen u_dut_b (
    .clk_i         (clk),
    .resetn_i      (b_resetn),
    .en_i          (b_en),
    .rate_sel_i    (b_rate),
    .resync_i      (b_resync),
    .os_tick_o     (b_os),
    .mid_tick_o    (b_mid),
    .bit_tick_o    (b_bt),
    .baud_clk_o    (b_baud),
    .os_phase_o    (b_ph),
    .rate_active_o (b_ra),
    .rate_ack_o    (b_ack)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Inputs held for cyc clocks, then outputs compared 1 time unit after the
  // last edge. Edge numbers in the comments count from the first enabled edge.
  typedef struct {
    logic       rstn;
    logic       en;
    logic [2:0] rate;
    logic       rsy;
    int         cyc;
    logic       os;
    logic       mid;
    logic       bt;
    logic       baud;
    logic [3:0] ph;
    logic [2:0] ra;
    logic       ack;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic rstn, input logic en, input logic [2:0] rate,
                              input logic rsy, input int cyc, input logic os,
                              input logic mid, input logic bt, input logic baud,
                              input logic [3:0] ph, input logic [2:0] ra, input logic ack);
    vec_t v;
    v.rstn = rstn; v.en = en; v.rate = rate; v.rsy = rsy; v.cyc = cyc;
    v.os = os; v.mid = mid; v.bt = bt; v.baud = baud; v.ph = ph; v.ra = ra; v.ack = ack;
    tbl.push_back(v);
  endfunction

  initial begin
    //   rstn en rate rsy cyc   os mid bt baud ph ra ack
    add(0, 0, 3, 0,   1,  0, 0, 0, 0,  0, 3, 0); // reset state
    add(1, 0, 3, 0,   2,  0, 0, 0, 0,  0, 3, 0); // idle
    add(1, 1, 3, 0,  31,  0, 0, 0, 0,  0, 3, 0); // E0..E30 no carry yet
    add(1, 1, 3, 0,   1,  1, 0, 0, 0,  1, 3, 0); // E31 first os_tick
    add(1, 1, 3, 0,   1,  0, 0, 0, 0,  1, 3, 0); // E32
    add(1, 1, 3, 0, 223,  1, 1, 0, 1,  8, 3, 0); // E255 mid_tick, baud up
    add(1, 1, 3, 0,   1,  0, 0, 0, 1,  8, 3, 0); // E256
    add(1, 1, 3, 0, 255,  1, 0, 1, 0,  0, 3, 0); // E511 bit_tick, baud down
    add(1, 1, 3, 0,   1,  0, 0, 0, 0,  0, 3, 0); // E512
    add(1, 1, 2, 0, 159,  1, 0, 0, 0,  5, 3, 0); // E671 request pending
    add(1, 1, 2, 0, 351,  0, 0, 0, 1, 15, 3, 0); // E1022 still old rate
    add(1, 1, 2, 0,   1,  1, 0, 1, 0,  0, 2, 1); // E1023 applied on bit_tick
    add(1, 1, 2, 0,   1,  0, 0, 0, 0,  0, 2, 0); // E1024 ack single cycle
    add(1, 1, 2, 0,  62,  0, 0, 0, 0,  0, 2, 0); // E1086
    add(1, 1, 2, 0,   1,  1, 0, 0, 0,  1, 2, 0); // E1087 spacing now 64
    add(1, 1, 2, 0, 512,  1, 0, 0, 1,  9, 2, 0); // E1599 phase 9
    add(1, 1, 2, 0,  10,  0, 0, 0, 1,  9, 2, 0); // E1609
    add(1, 1, 2, 1,   1,  0, 0, 0, 0,  0, 2, 0); // E1610 resync
    add(1, 1, 2, 0,  63,  0, 0, 0, 0,  0, 2, 0); // E1673
    add(1, 1, 2, 0,   1,  1, 0, 0, 0,  1, 2, 0); // E1674 resync+64
    add(1, 1, 2, 0, 447,  0, 0, 0, 0,  7, 2, 0); // E2121
    add(1, 1, 2, 0,   1,  1, 1, 0, 1,  8, 2, 0); // E2122 mid = resync+512
    add(1, 1, 2, 0,  63,  0, 0, 0, 1,  8, 2, 0); // E2185
    add(1, 1, 2, 1,   1,  0, 0, 0, 0,  0, 2, 0); // E2186 resync on carry edge
    add(1, 1, 3, 1,   1,  0, 0, 0, 0,  0, 3, 1); // E2187 resync applies rate
    add(1, 1, 3, 0,   1,  0, 0, 0, 0,  0, 3, 0); // E2188
    add(1, 1, 3, 0,  30,  0, 0, 0, 0,  0, 3, 0); // E2218
    add(1, 1, 3, 0,   1,  1, 0, 0, 0,  1, 3, 0); // E2219 resync+32
    add(1, 1, 3, 0, 287,  0, 0, 0, 1,  9, 3, 0); // E2506 mid-bit, carry due next
    add(1, 0, 3, 0,   1,  0, 0, 0, 0,  0, 3, 0); // en dropped on carry edge
    add(1, 0, 2, 0,   1,  0, 0, 0, 0,  0, 2, 1); // idle rate follows sel
    add(1, 0, 2, 0,   1,  0, 0, 0, 0,  0, 2, 0);
    add(1, 1, 2, 0,  63,  0, 0, 0, 0,  0, 2, 0); // re-enable
    add(1, 1, 2, 0,   1,  1, 0, 0, 0,  1, 2, 0); // first tick at 64th edge
    add(0, 1, 3, 0,   1,  0, 0, 0, 0,  0, 3, 0); // reset mid-run, no ack
    add(1, 1, 3, 0,  31,  0, 0, 0, 0,  0, 3, 0);
    add(1, 1, 3, 0,   1,  1, 0, 0, 0,  1, 3, 0); // clean restart

    a_resetn = 1'b0; a_en = 1'b0; a_rate = 3'd3; a_resync = 1'b0;
    b_resetn = 1'b0; b_en = 1'b0; b_rate = 3'd5; b_resync = 1'b0;

    foreach (tbl[i]) begin
      a_resetn = tbl[i].rstn;
      a_en     = tbl[i].en;
      a_rate   = tbl[i].rate;
      a_resync = tbl[i].rsy;
      repeat (tbl[i].cyc) @(posedge clk);
      #1;
      chk($sformatf("v%0d os_tick", i),     a_os,   tbl[i].os);
      chk($sformatf("v%0d mid_tick", i),    a_mid,  tbl[i].mid);
      chk($sformatf("v%0d bit_tick", i),    a_bt,   tbl[i].bt);
      chk($sformatf("v%0d baud_clk", i),    a_baud, tbl[i].baud);
      chk($sformatf("v%0d os_phase", i),    a_ph,   tbl[i].ph);
      chk($sformatf("v%0d rate_active", i), a_ra,   tbl[i].ra);
      chk($sformatf("v%0d rate_ack", i),    a_ack,  tbl[i].ack);
    end

    // Steady rate 3: os spacing 32, bit spacing 512, baud high 256 per bit.
    begin
      int last_os = -1;
      int last_bt = -1;
      int hi      = 0;
      int n_bt    = 0;
      for (int c = 0; c < 1200; c++) begin
        @(posedge clk); #1;
        if (a_os) begin
          if (last_os >= 0) chk("rate3 os spacing", c - last_os, 32);
          last_os = c;
        end
        if (a_bt) begin
          n_bt++;
          if (last_bt >= 0) begin
            chk("rate3 bit spacing", c - last_bt, 512);
            chk("rate3 baud high", hi, 256);
          end
          last_bt = c;
          hi = 0;
        end else if (a_baud) begin
          hi++;
        end
      end
      chk("rate3 bit_tick count", n_bt, 2);
    end

    // Default parameters, 115200: fractional increment 858993.
    @(posedge clk); #1;
    chk("B reset rate_active", b_ra, 5);
    chk("B reset os_tick", b_os, 0);
    b_resetn = 1'b1;
    b_en     = 1'b1;
    begin
      int n_os    = 0;
      int n_bt    = 0;
      int last_os = -1;
      int bad     = 0;
      int gmin    = 1000;
      int gmax    = 0;
      for (int c = 0; c < 36000; c++) begin
        @(posedge clk); #1;
        if (b_os) begin
          n_os++;
          if (last_os >= 0) begin
            if (c - last_os < gmin) gmin = c - last_os;
            if (c - last_os > gmax) gmax = c - last_os;
            if (c - last_os < 19 || c - last_os > 20) bad++;
          end
          last_os = c;
        end
        if (b_bt) n_bt++;
      end
      chk_range("B os_tick count", n_os, 1843, 1844);
      chk_range("B bit_tick count", n_bt, 115, 116);
      chk("B os spacing out of 19..20", bad, 0);
      chk_range("B min spacing", gmin, 19, 20);
      chk_range("B max spacing", gmax, 19, 20);
      chk("B rate_ack idle", b_ack, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_uart_baud_tick_gen
`default_nettype wire
